// File: rtl/fifo_rd_pkg.sv
// Shared types for the async-FIFO read-side drain stage.
package fifo_rd_pkg;

    localparam int BUF_DEPTH = 2;

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/fifo_rd_buf2.sv
// Two-entry head/tail output buffer; head_data reads as zero while empty.
module fifo_rd_buf2
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clr,
    input  logic [WIDTH-1:0] wdata,
    output occ_t             cnt,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem [BUF_DEPTH];
    logic             hd;
    logic             tl;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            hd  <= 1'b0;
            tl  <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
            cnt <= '0;
            hd  <= 1'b0;
            tl  <= 1'b0;
        end else begin
            if (push) begin
                mem[tl] <= wdata;
                tl      <= ~tl;
            end
            if (pop) hd <= ~hd;
            cnt <= cnt + occ_t'(push) - occ_t'(pop);
        end
    end

    assign head_data = (cnt != '0) ? mem[hd] : '0;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain: issues FIFO reads, absorbs the one-cycle read latency and
// re-presents words on a valid/ready stream through a 2-entry skid buffer.
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rempty,
    output logic             rinc,
    input  logic [WIDTH-1:0] rdata,
    input  logic             flush,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [CNT_W-1:0] xfer_cnt
);

    occ_t       cnt;
    logic       infl;
    logic       pop;
    logic       arrive;
    logic [2:0] occ_next;

    assign pop    = m_valid && m_ready;
    assign arrive = infl && !flush;

    // Occupancy including the word already in flight, net of this cycle's pop;
    // issuing only while this stays below 2 makes the 2-entry buffer lossless.
    assign occ_next = {1'b0, cnt} + {2'b00, infl} - {2'b00, pop};
    assign rinc     = rst_n && !flush && !rempty && (occ_next < 3'd2);

    assign m_valid = (cnt != '0);

    fifo_rd_buf2 #(.WIDTH(WIDTH)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (arrive),
        .pop       (pop),
        .clr       (flush),
        .wdata     (rdata),
        .cnt       (cnt),
        .head_data (m_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            infl     <= 1'b0;
            xfer_cnt <= '0;
        end else begin
            infl <= rinc;
            if (pop) xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomized bench for fifo_rd_stream against a queue-based FIFO/stream model.
module tb_fifo_rd_stream;

    localparam int W  = 8;
    localparam int CW = 12;   // narrow counter keeps the wrap test short
    localparam int N  = 8192;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rempty;
    logic          rinc;
    logic [W-1:0]  rdata = '0;
    logic          flush = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [W-1:0]  m_data;
    logic [CW-1:0] xfer_cnt;

    logic [W-1:0]  fifo_mem [N];
    int            wr_cnt = 0;
    int            rd_cnt = 0;
    logic [W-1:0]  exp_q [$];
    logic [CW-1:0] mx = '0;
    logic [W-1:0]  prev_data = '0;
    logic          prev_hold = 1'b0;
    int            n_chk = 0;
    int            n_fail = 0;
    int            fr, fv, fp, lp, nb, nr, base, to, need;
    logic [CW-1:0] xb, prev_x;
    logic [W-1:0]  got_q [$];
    logic [CW-1:0] seen_q [$];

    fifo_rd_stream #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rempty   (rempty),
        .rinc     (rinc),
        .rdata    (rdata),
        .flush    (flush),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .xfer_cnt (xfer_cnt)
    );

    always #5 clk = ~clk;

    assign rempty = (wr_cnt == rd_cnt);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] d);
        fifo_mem[wr_cnt % N] = d;
        wr_cnt++;
    endtask

    // FIFO model: registered read, read side reset along with the drain stage
    always @(posedge clk) begin
        if (!rst_n) rd_cnt <= wr_cnt;
        else if (rinc) begin
            rdata <= fifo_mem[rd_cnt % N];
            exp_q.push_back(fifo_mem[rd_cnt % N]);
            rd_cnt <= rd_cnt + 1;
        end
    end

    // Stream model: words read from the FIFO come out in order unless flushed/reset
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rinc_in_reset", rinc, 0);
            exp_q.delete();
            mx = '0;
            prev_hold = 1'b0;
        end else begin
            chk("occ_le_2", (int'(dut.u_buf.cnt) + int'(dut.infl)) <= 2, 1);
            chk("no_ovf_write", dut.arrive && dut.u_buf.cnt == 2'd2 && !(m_valid && m_ready), 0);
            chk("xfer_cnt", xfer_cnt, mx);
            if (!m_valid) chk("mdata_idle", m_data, 0);
            if (prev_hold) chk("hold", {m_valid, m_data}, {1'b1, prev_data});
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) chk("beat_extra", 1, 0);
                else chk("beat", m_data, exp_q.pop_front());
                mx = mx + 1'b1;
            end
            prev_hold = m_valid && !m_ready && !flush;
            prev_data = m_data;
            if (flush) exp_q.delete();
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step(2);
        rst_n = 1'b1;

        // idle with empty FIFO
        repeat (10) begin
            @(negedge clk);
            chk("idle_rinc", rinc, 0);
            chk("idle_valid", m_valid, 0);
            chk("idle_data", m_data, 0);
            chk("idle_xfer", xfer_cnt, 0);
        end
        step(1);

        // preloaded burst with m_ready high
        for (int i = 1; i <= 16; i++) push(W'(i));
        m_ready = 1'b1;
        fr = -1; fv = -1; fp = -1; lp = -1; nb = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rinc && fr < 0) fr = c;
            if (m_valid && fv < 0) fv = c;
            if (m_valid && m_ready) begin
                if (fp < 0) fp = c;
                lp = c;
                nb++;
            end
        end
        chk("first_latency", fv - fr, 2);
        chk("burst_beats", nb, 16);
        chk("burst_no_gap", lp - fp, 15);
        chk("burst_xfer", xfer_cnt, 16);
        step(1);

        // back-pressure: only two words absorbed
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'hA0 + W'(i));
        nr = 0;
        repeat (8) begin
            @(negedge clk);
            if (rinc) nr++;
        end
        chk("bp_rinc_pulses", nr, 2);
        chk("bp_cnt", dut.u_buf.cnt, 2);
        chk("bp_head", m_data, 8'hA0);
        step(1);
        m_ready = 1'b1;
        step(16);
        chk("bp_drain", exp_q.size(), 0);
        chk("bp_fifo_empty", wr_cnt - rd_cnt, 0);
        chk("bp_xfer", xfer_cnt, 24);

        // random back-pressure over 200 words
        base = int'(xfer_cnt);
        for (int i = 0; i < 200; i++) push(W'(i));
        to = 0;
        while (int'(xfer_cnt) - base != 200 && to < 3000) begin
            m_ready = 1'($urandom_range(0, 1));
            step(1);
            to++;
        end
        chk("rand_xfer", int'(xfer_cnt) - base, 200);
        m_ready = 1'b1;
        step(4);
        chk("rand_drain", exp_q.size(), 0);
        chk("rand_fifo_empty", wr_cnt - rd_cnt, 0);

        // flush with one buffered and one in-flight word
        m_ready = 1'b0;
        push(8'h30); push(8'h31); push(8'h32); push(8'h55); push(8'h56);
        step(6);
        chk("fl_pre_cnt", dut.u_buf.cnt, 2);
        m_ready = 1'b1;
        step(1);
        m_ready = 1'b0;
        chk("fl_setup_cnt", dut.u_buf.cnt, 1);
        chk("fl_setup_infl", dut.infl, 1);
        xb = xfer_cnt;
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        chk("fl_cnt", dut.u_buf.cnt, 0);
        chk("fl_valid", m_valid, 0);
        chk("fl_xfer", xfer_cnt, xb);
        m_ready = 1'b1;
        got_q.delete();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (m_valid && m_ready) got_q.push_back(m_data);
        end
        chk("fl_beats", got_q.size(), 2);
        if (got_q.size() >= 2) begin
            chk("fl_beat0", got_q[0], 8'h55);
            chk("fl_beat1", got_q[1], 8'h56);
        end
        step(1);

        // counter wrap
        need = 'hFFE - int'(xfer_cnt);
        for (int i = 0; i < need; i++) push(W'(i));
        to = 0;
        while (xfer_cnt != CW'('hFFE) && to < 6000) begin
            step(1);
            to++;
        end
        step(4);
        chk("wrap_pre", xfer_cnt, 'hFFE);
        push(8'hC0); push(8'hC1); push(8'hC2);
        seen_q.delete();
        prev_x = xfer_cnt;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (xfer_cnt != prev_x) seen_q.push_back(xfer_cnt);
            prev_x = xfer_cnt;
        end
        chk("wrap_steps", seen_q.size(), 3);
        if (seen_q.size() >= 3) begin
            chk("wrap_0", seen_q[0], 'hFFF);
            chk("wrap_1", seen_q[1], 'h000);
            chk("wrap_2", seen_q[2], 'h001);
        end
        step(1);

        // reset mid-stream
        for (int i = 0; i < 20; i++) push(8'h80 + W'(i));
        step(5);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_rinc", rinc, 0);
        step(1);
        chk("rst_valid", m_valid, 0);
        chk("rst_cnt", dut.u_buf.cnt, 0);
        chk("rst_infl", dut.infl, 0);
        chk("rst_xfer", xfer_cnt, 0);
        chk("rst_data", m_data, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) push(8'hE0 + W'(i));
        step(10);
        chk("post_rst_drain", exp_q.size(), 0);
        chk("post_rst_xfer", xfer_cnt, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
